// File: rtl/muldiv_pkg.sv
// Shared encodings for the sequential RISC-V M-extension multiply/divide unit.
// Opcodes follow funct3, so decode can forward the field unchanged.
package muldiv_pkg;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    localparam logic [1:0] MD_IDLE = 2'd0;
    localparam logic [1:0] MD_CALC = 2'd1;
    localparam logic [1:0] MD_DONE = 2'd2;

    // Bit 2 of funct3 separates the divide group from the multiply group.
    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    // The remainder ops are the upper pair of the divide group.
    function automatic logic op_is_rem(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    function automatic logic rs1_signed(input logic [2:0] op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
               (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic rs2_signed(input logic [2:0] op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the {hi, lo} working pair: add-shift-right for
// multiply (mode=0), shift-left trial-subtract (restoring) for divide (mode=1).
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            mode,
    input  logic [XLEN-1:0] opnd,
    input  logic [XLEN-1:0] hi_in,
    input  logic [XLEN-1:0] lo_in,
    output logic [XLEN-1:0] hi_out,
    output logic [XLEN-1:0] lo_out
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, opnd} : '0);
        shifted = {hi_in, lo_in[XLEN-1]};
        diff    = shifted - {1'b0, opnd};
        hi_out  = '0;
        lo_out  = '0;
        if (!mode) begin
            // The carry out of the add drops into the top of hi as the pair shifts right.
            hi_out = sum[XLEN:1];
            lo_out = {sum[0], lo_in[XLEN-1:1]};
        end else if (!diff[XLEN]) begin
            hi_out = diff[XLEN-1:0];
            lo_out = {lo_in[XLEN-2:0], 1'b1};
        end else begin
            hi_out = shifted[XLEN-1:0];
            lo_out = {lo_in[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit for EXECUTE: shift-add multiply and restoring
// divide on operand magnitudes, UNROLL steps per cycle, sign fixed on the last step.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int STEPS = XLEN / UNROLL;
    localparam int CW    = $clog2(STEPS + 1);

    logic [1:0]      state;
    logic [CW-1:0]   count;
    logic [2:0]      op_q;
    logic [XLEN-1:0] opnd_q;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic            neg_q;

    // Accept-time decode
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            special;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] init_opnd;
    logic [XLEN-1:0] init_lo;
    logic            init_neg;

    always_comb begin
        a_neg       = rs1_signed(op) & rs1_val[XLEN-1];
        b_neg       = rs2_signed(op) & rs2_val[XLEN-1];
        a_mag       = a_neg ? -rs1_val : rs1_val;
        b_mag       = b_neg ? -rs2_val : rs2_val;
        special     = 1'b0;
        special_res = '0;
        if (op_is_div(op)) begin
            if (rs2_val == '0) begin
                special     = 1'b1;
                special_res = op_is_rem(op) ? rs1_val : '1;
            end else if (!op[0] && rs1_val == {1'b1, {(XLEN-1){1'b0}}} && rs2_val == '1) begin
                special     = 1'b1;
                special_res = op_is_rem(op) ? '0 : rs1_val;
            end
        end
        // Multiply keeps the multiplier in lo; divide keeps the dividend in lo.
        init_opnd = op_is_div(op) ? b_mag : a_mag;
        init_lo   = op_is_div(op) ? a_mag : b_mag;
        // A remainder follows the dividend; products and quotients follow the xor.
        init_neg  = op_is_rem(op) ? a_neg : (a_neg ^ b_neg);
    end

    // Unrolled iteration chain
    logic [XLEN-1:0] hi_c [UNROLL+1];
    logic [XLEN-1:0] lo_c [UNROLL+1];

    assign hi_c[0] = hi_q;
    assign lo_c[0] = lo_q;

    for (genvar i = 0; i < UNROLL; i++) begin : g_step
        muldiv_step #(.XLEN(XLEN)) u_step (
            .mode   (op_is_div(op_q)),
            .opnd   (opnd_q),
            .hi_in  (hi_c[i]),
            .lo_in  (lo_c[i]),
            .hi_out (hi_c[i+1]),
            .lo_out (lo_c[i+1])
        );
    end

    // Sign correction and result select for the final step
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   div_raw;
    logic [XLEN-1:0]   final_res;

    always_comb begin
        prod      = {hi_c[UNROLL], lo_c[UNROLL]};
        div_raw   = op_is_rem(op_q) ? hi_c[UNROLL] : lo_c[UNROLL];
        final_res = '0;
        if (neg_q) begin
            prod    = -prod;
            div_raw = -div_raw;
        end
        if (op_is_div(op_q))
            final_res = div_raw;
        else if (op_q == MD_MUL)
            final_res = prod[XLEN-1:0];
        else
            final_res = prod[2*XLEN-1:XLEN];
    end

    assign in_ready = (state == MD_IDLE);
    assign busy     = (state != MD_IDLE);

    // NOTE: every register in this block is written with <= so all of them
    // update together on the edge; a blocking '=' would leak new values into
    // later reads within the same block and change the hardware.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= MD_IDLE;
            count     <= '0;
            op_q      <= MD_MUL;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_q     <= 1'b0;
            result    <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            state     <= MD_IDLE;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (in_valid) begin
                        op_q   <= op;
                        opnd_q <= init_opnd;
                        hi_q   <= '0;
                        lo_q   <= init_lo;
                        neg_q  <= init_neg;
                        if (special) begin
                            result    <= special_res;
                            out_valid <= 1'b1;
                            state     <= MD_DONE;
                        end else begin
                            count <= CW'(STEPS);
                            state <= MD_CALC;
                        end
                    end
                end
                MD_CALC: begin
                    hi_q  <= hi_c[UNROLL];
                    lo_q  <= lo_c[UNROLL];
                    count <= count - 1'b1;
                    if (count == CW'(1)) begin
                        result    <= final_res;
                        out_valid <= 1'b1;
                        state     <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= MD_IDLE;
                    end
                end
                default: begin
                    state     <= MD_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench: two muldiv_seq instances (UNROLL=1 and UNROLL=4) share
// stimulus and are compared against a plain-arithmetic RISC-V M-extension model.
module tb_muldiv_seq;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs1_val = '0;
    logic [31:0] rs2_val = '0;
    logic        out_ready = 1'b0;

    logic        in_ready1, out_valid1, busy1;
    logic [31:0] result1;
    logic        in_ready4, out_valid4, busy4;
    logic [31:0] result4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    muldiv_seq #(.XLEN(32), .UNROLL(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
        .op(op), .rs1_val(rs1_val), .rs2_val(rs2_val), .out_valid(out_valid1),
        .out_ready(out_ready), .result(result1), .busy(busy1)
    );

    muldiv_seq #(.XLEN(32), .UNROLL(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
        .op(op), .rs1_val(rs1_val), .rs2_val(rs2_val), .out_valid(out_valid4),
        .out_ready(out_ready), .result(result4), .busy(busy4)
    );

    // Reference model: RISC-V M semantics from wide integer arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        p  = '0;
        case (o)
            OP_MUL:    begin p = sa * sb; return p[31:0]; end
            OP_MULH:   begin p = sa * sb; return p[63:32]; end
            OP_MULHSU: begin p = sa * ub; return p[63:32]; end
            OP_MULHU:  begin p = longint'({32'b0, a}) * ub; return p[63:32]; end
            OP_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb;
                return p[31:0];
            end
            OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb;
                return p[31:0];
            end
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] o, input logic [31:0] a,
                                       input logic [31:0] b, input int unroll);
        bit is_signed_div;
        is_signed_div = (o == OP_DIV) || (o == OP_REM);
        if (o >= OP_DIV && (b == 0 || (is_signed_div && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 32 / unroll + 1;
    endfunction

    // Present one request; returns #1 after the accept edge with junk on the operand bus.
    task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        op       = o;
        rs1_val  = a;
        rs2_val  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op       = 3'($urandom);
        rs1_val  = $urandom;
        rs2_val  = $urandom;
    endtask

    // Latency counts the accept edge as cycle 1; -1 means the bound expired.
    task automatic wait_both(output int lat1, output int lat4,
                             output logic [31:0] r1, output logic [31:0] r4);
        bit g1, g4;
        g1 = 0; g4 = 0; lat1 = -1; lat4 = -1; r1 = '0; r4 = '0;
        for (int cyc = 1; cyc <= 80 && !(g1 && g4); cyc++) begin
            if (!g1 && out_valid1) begin g1 = 1; lat1 = cyc; r1 = result1; end
            if (!g4 && out_valid4) begin g4 = 1; lat4 = cyc; r4 = result4; end
            if (!(g1 && g4)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r1, output logic [31:0] r4,
                          output int lat1, output int lat4, output bit idle_after);
        start_op(o, a, b);
        wait_both(lat1, lat4, r1, r4);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        idle_after = in_ready1 && in_ready4 && !out_valid1 && !out_valid4;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if ({out_valid1, in_ready1, busy1, out_valid4, in_ready4, busy4} !== 6'b010_010) begin
            n_err++;
            $display("FAIL reset_flags: got ov/ir/busy=%b%b%b,%b%b%b expected 010,010",
                     out_valid1, in_ready1, busy1, out_valid4, in_ready4, busy4);
        end
        n_vec++;
        if (result1 !== 32'h0 || result4 !== 32'h0) begin
            n_err++;
            $display("FAIL reset_result: got %h/%h expected 00000000", result1, result4);
        end
    endtask

    task automatic test_directed();
        logic [2:0]  t_op  [16] = '{OP_MUL, OP_MULH, OP_MULH, OP_MULHU, OP_MULHSU, OP_DIV,
                                    OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_DIVU, OP_REM,
                                    OP_REMU, OP_DIV, OP_REM, OP_DIVU};
        logic [31:0] t_a   [16] = '{32'd7, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                    32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5,
                                    32'd5, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd9};
        logic [31:0] t_b   [16] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF,
                                    32'hFFFF_FFFF, 32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
                                    32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3};
        logic [31:0] t_exp [16] = '{32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'h4000_0000, 32'hFFFF_FFFE,
                                    32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd5, 32'h8000_0000,
                                    32'd0, 32'd3};
        bit          t_spc [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0};
        logic [31:0] r1, r4;
        int          l1, l4;
        bit          idle;
        for (int i = 0; i < 16; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], r1, r4, l1, l4, idle);
            n_vec++;
            if (r1 !== t_exp[i] || r4 !== t_exp[i]) begin
                n_err++;
                $display("FAIL directed_result[%0d] op=%0d: got %h/%h expected %h",
                         i, t_op[i], r1, r4, t_exp[i]);
            end
            n_vec++;
            if (l1 !== (t_spc[i] ? 1 : 33) || l4 !== (t_spc[i] ? 1 : 9)) begin
                n_err++;
                $display("FAIL directed_latency[%0d] op=%0d: got %0d/%0d expected %0d/%0d",
                         i, t_op[i], l1, l4, t_spc[i] ? 1 : 33, t_spc[i] ? 1 : 9);
            end
            n_vec++;
            if (!idle) begin
                n_err++;
                $display("FAIL directed_release[%0d]: got not idle after out_ready expected idle", i);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] a, b, exp, r1, r4;
        int          l1, l4;
        bit          idle;
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
                3: begin a = -$urandom_range(0, 300); b = $urandom_range(1, 20); end
                default: ;
            endcase
            exp = ref_result(o, a, b);
            run_op(o, a, b, r1, r4, l1, l4, idle);
            n_vec++;
            if (r1 !== exp || r4 !== exp) begin
                n_err++;
                $display("FAIL random_result op=%0d a=%h b=%h: got %h/%h expected %h",
                         o, a, b, r1, r4, exp);
            end
            n_vec++;
            if (l1 !== ref_latency(o, a, b, 1) || l4 !== ref_latency(o, a, b, 4) || !idle) begin
                n_err++;
                $display("FAIL random_timing op=%0d: got lat %0d/%0d idle=%0d expected %0d/%0d idle=1",
                         o, l1, l4, idle, ref_latency(o, a, b, 1), ref_latency(o, a, b, 4));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b, exp, r1, r4;
        int          l1, l4;
        bit          held;
        a = $urandom;
        b = $urandom;
        exp = ref_result(OP_MULHU, a, b);
        start_op(OP_MULHU, a, b);
        wait_both(l1, l4, r1, r4);
        n_vec++;
        if (r1 !== exp || r4 !== exp) begin
            n_err++;
            $display("FAIL backpressure_result: got %h/%h expected %h", r1, r4, exp);
        end
        // A request offered while DONE must be ignored.
        in_valid = 1'b1;
        op       = OP_DIVU;
        rs1_val  = 32'd50;
        rs2_val  = 32'd5;
        held = 1;
        repeat (10) begin
            @(posedge clk); #1;
            if (!out_valid1 || !out_valid4 || result1 !== exp || result4 !== exp ||
                in_ready1 || in_ready4)
                held = 0;
        end
        in_valid = 1'b0;
        n_vec++;
        if (!held) begin
            n_err++;
            $display("FAIL backpressure_hold: got out_valid/result/in_ready disturbed expected held with %h", exp);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_vec++;
        if ({busy1, out_valid1, in_ready1, busy4, out_valid4, in_ready4} !== 6'b001_001) begin
            n_err++;
            $display("FAIL backpressure_release: got busy/ov/ir=%b%b%b,%b%b%b expected 001,001",
                     busy1, out_valid1, in_ready1, busy4, out_valid4, in_ready4);
        end
    endtask

    task automatic test_flush();
        logic [31:0] hold1, hold4;
        bit          quiet;
        start_op(OP_DIV, $urandom, $urandom_range(1, 1000));
        repeat (10) begin @(posedge clk); #1; end
        hold1 = result1;
        hold4 = result4;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_vec++;
        if ({busy1, out_valid1, busy4, out_valid4} !== 4'b0000) begin
            n_err++;
            $display("FAIL flush_state: got busy/ov=%b%b,%b%b expected 00,00",
                     busy1, out_valid1, busy4, out_valid4);
        end
        n_vec++;
        if (result1 !== hold1 || result4 !== hold4) begin
            n_err++;
            $display("FAIL flush_result_hold: got %h/%h expected %h/%h", result1, result4, hold1, hold4);
        end
        flush    = 1'b1;
        in_valid = 1'b1;
        op       = OP_DIVU;
        rs1_val  = 32'd9;
        rs2_val  = 32'd3;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        n_vec++;
        if (busy1 || busy4) begin
            n_err++;
            $display("FAIL flush_blocks_accept: got busy=%b%b expected 00", busy1, busy4);
        end
        quiet = 1;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid1 || out_valid4) quiet = 0;
        end
        n_vec++;
        if (!quiet) begin
            n_err++;
            $display("FAIL flush_no_out_valid: got out_valid after flush expected none");
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] r1, r4;
        int          l1, l4;
        bit          idle, quiet;
        start_op(OP_MUL, $urandom, $urandom);
        repeat (4) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({busy1, out_valid1, in_ready1, busy4, out_valid4, in_ready4} !== 6'b001_001 ||
            result1 !== 32'h0 || result4 !== 32'h0) begin
            n_err++;
            $display("FAIL async_reset: got busy/ov/ir=%b%b%b,%b%b%b res=%h/%h expected 001,001 res 0",
                     busy1, out_valid1, in_ready1, busy4, out_valid4, in_ready4, result1, result4);
        end
        @(negedge clk) rst = 1'b0;
        quiet = 1;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid1 || out_valid4 || busy1 || busy4) quiet = 0;
        end
        n_vec++;
        if (!quiet) begin
            n_err++;
            $display("FAIL async_reset_quiet: got activity after release expected idle");
        end
        run_op(OP_DIVU, 32'd9, 32'd3, r1, r4, l1, l4, idle);
        n_vec++;
        if (r1 !== 32'd3 || r4 !== 32'd3 || l1 !== 33 || l4 !== 9) begin
            n_err++;
            $display("FAIL post_reset_divu: got %h/%h lat %0d/%0d expected 00000003 lat 33/9",
                     r1, r4, l1, l4);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Parametrised, multi-cycle RISC-V M-extension unit: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits beside the single-cycle integer ALU in EXECUTE; the core stalls on `in_ready`/`out_valid`.
- Iterative shift-add multiply and restoring divide, UNROLL bits per cycle, valid/ready on both sides, pipeline flush support.

Parameters:
- XLEN, 32, operand/result width in bits.
- UNROLL, 1, bits retired per compute cycle; legal values 1, 2, 4; must divide XLEN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  abort any in-flight operation.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request.
- op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1_val  in  XLEN  multiplicand / dividend.
- rs2_val  in  XLEN  multiplier / divisor.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- result  out  XLEN  result value.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, any state): state=IDLE, count=0, result=0, out_valid=0; in_ready=1 combinationally from IDLE; busy=0.
- States: IDLE, CALC, DONE.
- IDLE, handshake: `in_valid && in_ready` captures op, operand magnitudes and result-sign flags.
  - Signedness: MUL/MULH/DIV/REM treat both operands as signed. MULHSU treats rs1 as signed, rs2 as unsigned. The rest are unsigned.
  - Special divide cases go straight to DONE with the fixed result.
  - Otherwise go to CALC with count=XLEN/UNROLL.
- Special divide cases, decided at accept:
  - Divisor==0: DIV/DIVU -> all ones; REM/REMU -> rs1_val.
  - Signed overflow (rs1 = 1 followed by zeros, rs2 = all ones) on DIV -> rs1_val; on REM -> 0.
- CALC: each cycle applies UNROLL iteration steps and decrements count.
  - On the count==1 cycle, the final step, sign correction and result select are registered; go to DONE.
  - Multiply: 2*XLEN product of magnitudes, negated if sign flag set. MUL returns low half; MULH/MULHSU/MULHU return high half.
  - Divide: quotient negated if operand signs differ (DIV). Remainder takes the dividend's sign (REM).
- Latency, accept edge to out_valid=1:
  - Normal operation: XLEN/UNROLL+1 cycles (33 at defaults).
  - Special divide cases: 1 cycle.
- DONE: out_valid=1 and result stable until `out_ready` is sampled high; then go to IDLE.
  - No new request is accepted in the same cycle (in_ready=0 in DONE).
  - out_valid is low in IDLE and CALC.
- flush: has priority over every transition. Next state is IDLE, out_valid=0, count=0; result holds its last value.
  - flush together with in_valid in IDLE: the request is not accepted.
- Inputs are ignored outside the IDLE handshake; operand changes during CALC have no effect.
- All arithmetic is modulo 2^XLEN or 2^(2*XLEN); negation is two's complement.
- Reset asserted mid-CALC: immediate IDLE; no spurious out_valid after release.

Decomposition:
- Shared defines file `muldiv_defs.v`: op encodings (MD_MUL..MD_REMU) and state encodings (MD_IDLE, MD_CALC, MD_DONE). Both are included by this block and by decode.
- One sub-module, `muldiv_step`: combinational single-bit iteration (add-shift for multiply, trial-subtract for divide, selected by a mode input). It is instantiated UNROLL times in a chain inside muldiv_seq.

Test Plan:
- MUL 7 x 0xFFFFFFFD, defaults -> out_valid exactly 33 cycles after accept, result 0xFFFFFFEB; MULH same operands -> 0xFFFFFFFF.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV/DIVU/REM/REMU with rs2=0, rs1=5 -> 0xFFFFFFFF, 0xFFFFFFFF, 5, 5 after 1 cycle; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same -> 0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, result stable, in_ready stays 0; out_ready=1 -> IDLE next cycle.
- flush at CALC cycle 12, then async rst mid-CALC -> IDLE next edge / immediately, no out_valid; a fresh DIVU 9/3 afterwards -> 3; repeat all directed ops with UNROLL=4 -> same results, 9-cycle latency.
